// File: rtl/regfile_write_queue_if.sv
// Write-request bus between a producer and the register-bank write queue.
// Carries the valid/ready request channel, retirement controls and the
// bank-facing outputs (enables, data, pending mask, occupancy).
interface regfile_write_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
);
  localparam int NUM_REG = 2 ** ADDR_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              stall;
  logic              flush;
  logic [NUM_REG-1:0] en;
  logic [DATA_W-1:0] d_in;
  logic [NUM_REG-1:0] pending;
  logic [CNT_W-1:0]  count;

  // Producer / controller side.
  modport master (
    output wr_valid, wr_addr, wr_data, stall, flush,
    input  wr_ready, en, d_in, pending, count
  );

  // Queue side.
  modport slave (
    input  wr_valid, wr_addr, wr_data, stall, flush,
    output wr_ready, en, d_in, pending, count
  );
endinterface

// File: rtl/regfile_write_queue.sv
// Write-side front end for the enabled register bank. Requests are buffered
// in a small in-order FIFO and retired one per cycle as a registered one-hot
// enable vector plus shared data bus. A pending mask flags every register
// with a queued or currently-retiring write.
module regfile_write_queue #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int NUM_REG = 8,
  parameter int DEPTH   = 4
) (
  input logic                  clk,
  input logic                  reset,
  regfile_write_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // FIFO storage
  logic [ADDR_W-1:0]  r_addr [DEPTH];
  logic [DATA_W-1:0]  r_data [DEPTH];

  // Control state
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [NUM_REG-1:0] r_en;
  logic [DATA_W-1:0]  r_d_in;

  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic [NUM_REG-1:0] w_head_onehot;
  logic [NUM_REG-1:0] w_pending;

  // Ready depends only on registered occupancy and the flush/reset inputs,
  // never on wr_valid, so there is no combinational valid->ready loop.
  assign w_ready = (r_count != CNT_W'(DEPTH)) && !bus.flush && !reset;
  assign w_push  = bus.wr_valid && w_ready;
  assign w_pop   = (r_count != '0) && !bus.stall && !bus.flush;

  assign w_head_onehot = NUM_REG'(1) << r_addr[r_head];

  // Pending mask: every live FIFO entry plus the write retiring right now.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    w_pending = r_en;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < r_count) begin
        w_pending[r_addr[r_head + PTR_W'(k)]] = 1'b1;
      end
    end
  end

  // Entry storage: written at tail on every accepted request.
  // NOTE: the storage array has no reset; occupancy (r_count) alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.wr_addr;
      r_data[r_tail] <= bus.wr_data;
    end
  end

  // Pointers, occupancy and registered bank outputs; flush beats stall and push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_en    <= '0;
      r_d_in  <= '0;
    end else if (bus.flush) begin
      // An enable already high this cycle still completes in the bank;
      // only the queued entries are discarded.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_en    <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
        r_en   <= w_head_onehot;
        r_d_in <= r_data[r_head];
      end else begin
        r_en   <= '0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.wr_ready = w_ready;
  assign bus.en       = r_en;
  assign bus.d_in     = r_d_in;
  assign bus.pending  = w_pending;
  assign bus.count    = r_count;
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue. The driver issues hand-built
// vectors and pushes each expected retirement into a queue; an independent
// monitor pops and compares whenever an enable pulse appears.
module tb_regfile_write_queue;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 3;
  localparam int NUM_REG = 8;
  localparam int DEPTH   = 4;

  typedef struct packed {
    logic [NUM_REG-1:0] en;
    logic [DATA_W-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  regfile_write_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  regfile_write_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_REG(NUM_REG),
    .DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive a request, check ready against the expected value,
  // record the expected retirement if it should be accepted, then move to
  // the next falling edge.
  task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic exp_rdy, input string nm);
    exp_t e;
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    #1;
    if (v) check({nm, "_ready"}, 64'(bus.wr_ready), 64'(exp_rdy));
    if (v && exp_rdy) begin
      e.en   = NUM_REG'(1) << a;
      e.data = d;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, "idle");
  endtask

  // Monitor: every enable pulse must match the oldest expected retirement.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && bus.en != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_en", 64'(bus.en), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_en",   64'(bus.en),   64'(e.en));
        check("sb_d_in", 64'(bus.d_in), 64'(e.data));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",   64'(bus.wr_ready), 64'(0));
    check("rst_en",      64'(bus.en),       64'(0));
    check("rst_d_in",    64'(bus.d_in),     64'(0));
    check("rst_pending", 64'(bus.pending),  64'(0));
    check("rst_count",   64'(bus.count),    64'(0));
    reset = 1'b0;

    // Single write addr 3, latency and pending window
    step(1'b1, 3'd3, 32'hDEADBEEF, 1'b1, "single");
    check("single_count1",   64'(bus.count),   64'(1));
    check("single_pend1",    64'(bus.pending), 64'(8'h08));
    check("single_en1",      64'(bus.en),      64'(0));
    idle(1);
    check("single_pend2",    64'(bus.pending), 64'(8'h08));
    check("single_count2",   64'(bus.count),   64'(0));
    idle(1);
    check("single_pend3",    64'(bus.pending), 64'(0));
    check("single_en3",      64'(bus.en),      64'(0));

    // Fill under stall, full back-pressure, then drain in order
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ADDR_W'(i), 32'hA000_0000 + 32'(i), 1'b1, "fill");
      check("fill_count", 64'(bus.count), 64'(i + 1));
    end
    step(1'b1, 3'd4, 32'hA000_0004, 1'b0, "full");
    check("full_count", 64'(bus.count), 64'(4));
    check("full_pend",  64'(bus.pending), 64'(8'h0F));
    bus.stall = 1'b0;
    step(1'b1, 3'd4, 32'hA000_0004, 1'b0, "full_pop");
    check("fullpop_count", 64'(bus.count), 64'(3));
    step(1'b1, 3'd4, 32'hA000_0004, 1'b1, "fifth");
    check("fifth_count", 64'(bus.count), 64'(3));
    idle(4);
    check("drain_count", 64'(bus.count), 64'(0));

    // Steady push+pop at occupancy 2
    bus.stall = 1'b1;
    step(1'b1, 3'd5, 32'hB000_0000, 1'b1, "pre");
    step(1'b1, 3'd6, 32'hB000_0001, 1'b1, "pre");
    bus.stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, ADDR_W'(i), 32'hC000_0000 + 32'(i), 1'b1, "stream");
      check("stream_count", 64'(bus.count), 64'(2));
    end
    idle(3);
    check("stream_drain", 64'(bus.count), 64'(0));

    // Two writes to the same register retire in order
    step(1'b1, 3'd7, 32'h1111_1111, 1'b1, "same");
    step(1'b1, 3'd7, 32'h2222_2222, 1'b1, "same");
    idle(3);
    check("same_last_d_in", 64'(bus.d_in), 64'(32'h2222_2222));
    check("same_en_idle",   64'(bus.en),   64'(0));

    // Flush with three queued entries and a request on the bus
    bus.stall = 1'b1;
    step(1'b1, 3'd1, 32'hF000_0001, 1'b1, "preflush");
    step(1'b1, 3'd2, 32'hF000_0002, 1'b1, "preflush");
    step(1'b1, 3'd5, 32'hF000_0005, 1'b1, "preflush");
    check("preflush_count", 64'(bus.count),   64'(3));
    check("preflush_pend",  64'(bus.pending), 64'(8'h26));
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 3'd6;
    bus.wr_data  = 32'hF000_0006;
    #1;
    check("flush_ready", 64'(bus.wr_ready), 64'(0));
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.stall    = 1'b0;
    check("flush_count", 64'(bus.count),   64'(0));
    check("flush_pend",  64'(bus.pending), 64'(0));
    check("flush_en",    64'(bus.en),      64'(0));
    idle(4);
    check("postflush_count", 64'(bus.count), 64'(0));

    // Asynchronous reset mid-operation: count=3 with en=0x04 in flight
    bus.stall = 1'b1;
    step(1'b1, 3'd2, 32'hE000_0002, 1'b1, "prerst");
    step(1'b1, 3'd4, 32'hE000_0004, 1'b1, "prerst");
    step(1'b1, 3'd5, 32'hE000_0005, 1'b1, "prerst");
    step(1'b1, 3'd6, 32'hE000_0006, 1'b1, "prerst");
    bus.stall = 1'b0;
    idle(1);
    check("prerst_count", 64'(bus.count),   64'(3));
    check("prerst_en",    64'(bus.en),      64'(8'h04));
    check("prerst_pend",  64'(bus.pending), 64'(8'h74));
    #2;
    reset = 1'b1;
    #1;
    check("arst_en",    64'(bus.en),       64'(0));
    check("arst_pend",  64'(bus.pending),  64'(0));
    check("arst_count", 64'(bus.count),    64'(0));
    check("arst_ready", 64'(bus.wr_ready), 64'(0));
    exp_q.delete();
    @(negedge clk);
    check("arst_ready_hold", 64'(bus.wr_ready), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_ready", 64'(bus.wr_ready), 64'(1));
    @(negedge clk);
    idle(3);
    check("rel_count", 64'(bus.count), 64'(0));

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side front end for the 8 x 32-bit enabled register bank.
- Accepts write requests (address + data) over a valid/ready handshake and buffers them in a small in-order FIFO.
- Retires at most one request per cycle as a registered one-hot `en` vector plus a shared `d_in` bus, which drive the bank directly.
- Exports a per-register `pending` mask so read-side logic can detect in-flight writes.

Parameters:
- DATA_W, 32, data width; must match the bank register width.
- ADDR_W, 3, register address width.
- NUM_REG, 8, number of registers; fixed at 2**ADDR_W.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request present.
- wr_ready  out  1  queue can accept this cycle.
- wr_addr  in  ADDR_W  target register index.
- wr_data  in  DATA_W  write data.
- stall  in  1  suppress retirement this cycle.
- flush  in  1  synchronous discard of all queued requests.
- en  out  NUM_REG  one-hot (or zero) bank write enables, registered.
- d_in  out  DATA_W  bank write data, registered.
- pending  out  NUM_REG  bit i = a queued or currently-retiring write targets register i.
- count  out  $clog2(DEPTH+1)  number of queued entries.

Behaviour:
- Reset (async, asserted): head=tail=0, count=0, en=0, d_in=0, pending=0, wr_ready=0. After deassertion wr_ready=1 from the first edge.
- wr_ready = (count != DEPTH) && !flush && !reset. No combinational path from wr_valid to wr_ready.
- Accept = wr_valid && wr_ready. On an accept edge, {addr,data} is written at tail, then tail increments mod DEPTH.
- Pop condition: count != 0 && !stall && !flush. On a pop edge:
  - en <= one-hot(head.addr) and d_in <= head.data;
  - head increments mod DEPTH.
- Otherwise en <= 0 and d_in holds its previous value.
- en is high for exactly one cycle per retired entry. The bank captures on the following edge.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- Full (count=DEPTH): wr_ready=0. A pop that edge frees a slot, visible as wr_ready=1 the next cycle. There is no same-cycle full pass-through.
- Empty: no bypass; minimum latency below applies.
- Latency: accepted at edge N, earliest pop at edge N+1 (en high during cycle N+1..N+2), register updated at edge N+2.
- Ordering is strictly FIFO. Repeated writes to the same address all retire in order, so the last one wins in the bank.
- stall: FIFO frozen (pushes still allowed), en=0 next cycle.
- flush: priority over stall and push.
  - Next edge: head=tail=0, count=0, en=0.
  - Any en already high in the flush cycle still completes; that write was retired the previous edge.
  - A request presented during flush is not accepted (wr_ready=0).
- pending is combinational from registered state: OR over valid FIFO entries of one-hot(addr), OR the current en vector.
- count is registered and never exceeds DEPTH.
- Mid-operation reset clears everything immediately. Queued writes are lost and en drops to 0 asynchronously.

Test Plan:
- Reset release, then single write addr=3 data=0xDEADBEEF at edge 1:
  - en=0x08, d_in=0xDEADBEEF during the cycle after edge 2;
  - pending[3]=1 from after edge 1 until en drops.
- Back-to-back 5 writes addr 0..4 with stall held high:
  - 4 accepted, then wr_ready=0, count=4;
  - release stall: en sequence 0x01,0x02,0x04,0x08 on consecutive cycles, then 5th accepted and retires as 0x10.
- Continuous push+pop at count=2 for 10 cycles: count stays 2, one en pulse per cycle, data order matches input.
- Two writes to addr 7 (0x11111111 then 0x22222222): two en=0x80 pulses in order; last d_in=0x22222222.
- Queue 3 entries, assert flush for 1 cycle with wr_valid=1:
  - count=0 and pending=0 next cycle;
  - the flush-cycle request is not accepted;
  - no further en pulses.
- Assert reset while count=3 and en=0x04: en, pending and count go to 0 immediately; wr_ready=0 until reset deasserts.
